// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> DECODE -> EXEC loop with PC and IR.
// Optional HALT on opcode 111 is enabled by defining FETCH_HALT_EN.
module fetch_sequencer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    output logic       imem_req_o,
    output logic [4:0] imem_addr_o,
    input  logic       imem_ack_i,
    input  logic [7:0] imem_data_i,
    output logic [2:0] op_o,
    output logic [4:0] arg_o,
    output logic       ex_o,
    input  logic       jmp_i,
    input  logic       z_i,
    input  logic       c_i,
    output logic [4:0] pc_o,
    output logic       halt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
`ifdef FETCH_HALT_EN
        S_HALT   = 3'd4,
`endif
        S_EXEC   = 3'd3
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [4:0] pc_r;
    logic [4:0] pc_nx_s;
    logic [7:0] ir_r;
    logic [7:0] ir_nx_s;
    logic       jump_s;
    logic       req_r;
    logic       ex_r;
    logic       halt_r;

    // Next-state, next-PC and instruction-register load decisions
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ir_nx_s    = ir_r;
        jump_s     = jmp_i && ((ir_r[7:5] == 3'b100) ||
                               ((ir_r[7:5] == 3'b101) && z_i) ||
                               ((ir_r[7:5] == 3'b110) && c_i));
        case (state_r)
            S_IDLE: begin
                if (run_i) begin
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    ir_nx_s    = imem_data_i;
                    state_nx_s = S_DECODE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                state_nx_s = S_EXEC;
            end
            S_EXEC: begin
`ifdef FETCH_HALT_EN
                if (ir_r[7:5] == 3'b111) begin
                    state_nx_s = S_HALT;
                end else begin
`endif
                    pc_nx_s    = jump_s ? ir_r[4:0] : (pc_r + 5'd1);
                    state_nx_s = run_i ? S_FETCH : S_IDLE;
`ifdef FETCH_HALT_EN
                end
`endif
            end
`ifdef FETCH_HALT_EN
            S_HALT: begin
                state_nx_s = S_HALT;
            end
`endif
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, PC, IR and the registered strobes derived from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
            pc_r    <= 5'd0;
            ir_r    <= 8'd0;
            req_r   <= 1'b0;
            ex_r    <= 1'b0;
            halt_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            ir_r    <= ir_nx_s;
            req_r   <= (state_nx_s == S_FETCH);
            ex_r    <= (state_nx_s == S_EXEC);
`ifdef FETCH_HALT_EN
            halt_r  <= (state_nx_s == S_HALT);
`else
            halt_r  <= 1'b0;
`endif
        end
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_r;
    assign op_o        = ir_r[7:5];
    assign arg_o       = ir_r[4:0];
    assign ex_o        = ex_r;
    assign pc_o        = pc_r;
    assign halt_o      = halt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small instruction memory responder.
// Expected values are hand-computed from the instruction table below.
module tb_fetch_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       run_i = 1'b0;
    logic       imem_req_o;
    logic [4:0] imem_addr_o;
    logic       imem_ack_i = 1'b0;
    logic [7:0] imem_data_i = 8'd0;
    logic [2:0] op_o;
    logic [4:0] arg_o;
    logic       ex_o;
    logic       jmp_i = 1'b0;
    logic       z_i = 1'b0;
    logic       c_i = 1'b0;
    logic [4:0] pc_o;
    logic       halt_o;

    logic [7:0] mem [32];
    int         ack_delay = 0;
    int         wait_cnt = 0;
    logic       spur = 1'b0;
    int         checks = 0;
    int         errors = 0;

    fetch_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .op_o(op_o), .arg_o(arg_o), .ex_o(ex_o),
        .jmp_i(jmp_i), .z_i(z_i), .c_i(c_i),
        .pc_o(pc_o), .halt_o(halt_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory responder: acks after ack_delay wait cycles, or drives a stray ack when spur is set
    always @(negedge clk_i) begin
        if (imem_req_o) begin
            if (wait_cnt == ack_delay) begin
                imem_ack_i  = 1'b1;
                imem_data_i = mem[imem_addr_o];
                wait_cnt    = 0;
            end else begin
                imem_ack_i  = 1'b0;
                wait_cnt    = wait_cnt + 1;
            end
        end else begin
            imem_ack_i  = spur;
            imem_data_i = spur ? 8'hFF : 8'h00;
            wait_cnt    = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One instruction from IDLE: checks fetch address, latency and the resulting PC
    task automatic do_instr(input int dly, input logic jmp, input logic z, input logic c,
                            input logic [4:0] start_pc, input logic [4:0] end_pc);
        int n;
        ack_delay = dly;
        jmp_i = jmp;
        z_i = z;
        c_i = c;
        run_i = 1'b1;
        tick();
        check("fetch_addr", {27'd0, imem_addr_o}, {27'd0, start_pc});
        check("fetch_req", {31'd0, imem_req_o}, 32'd1);
        n = 1;
        while (!ex_o && n < 40) begin
            tick();
            n = n + 1;
        end
        check("latency", n, 3 + dly);
        run_i = 1'b0;
        tick();
        check("pc_after", {27'd0, pc_o}, {27'd0, end_pc});
        check("ex_after", {31'd0, ex_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h41;
        mem[1]  = 8'h00;
        mem[2]  = 8'hE0;
        mem[3]  = 8'hB0;
        mem[4]  = 8'hB0;
        mem[16] = 8'hC5;
        mem[5]  = 8'h9F;
        mem[6]  = 8'h9F;
        mem[31] = 8'h20;

        #1 rst_i = 1'b1;
        #2;
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_ex", {31'd0, ex_o}, 32'd0);
        check("rst_pc", {27'd0, pc_o}, 32'd0);
        check("rst_ir", {24'd0, op_o, arg_o}, 32'd0);
        check("rst_halt", {31'd0, halt_o}, 32'd0);
        tick();
        tick();

        // Reset pulse in the middle of a fetch
        rst_i = 1'b0;
        ack_delay = 3;
        run_i = 1'b1;
        tick();
        check("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        rst_i = 1'b1;
        #1;
        check("midrst_req", {31'd0, imem_req_o}, 32'd0);
        check("midrst_pc", {27'd0, pc_o}, 32'd0);
        tick();
        check("midrst_ex", {31'd0, ex_o}, 32'd0);
        tick();
        run_i = 1'b0;
        rst_i = 1'b0;

        // First instruction: mem[0]=0x41, ack in the first fetch cycle
        ack_delay = 0;
        tick();
        run_i = 1'b1;
        tick();
        check("t1_req", {31'd0, imem_req_o}, 32'd1);
        check("t1_addr", {27'd0, imem_addr_o}, 32'd0);
        check("t1_ex_c1", {31'd0, ex_o}, 32'd0);
        tick();
        check("t1_op", {29'd0, op_o}, 32'd2);
        check("t1_arg", {27'd0, arg_o}, 32'd1);
        check("t1_ex_c2", {31'd0, ex_o}, 32'd0);
        check("t1_req_c2", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("t1_ex_c3", {31'd0, ex_o}, 32'd1);
        run_i = 1'b0;
        tick();
        check("t1_pc", {27'd0, pc_o}, 32'd1);
        check("t1_ex_c4", {31'd0, ex_o}, 32'd0);

        // Four wait cycles, run dropped during DECODE
        ack_delay = 4;
        run_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_addr", {27'd0, imem_addr_o}, 32'd1);
            check("t2_req", {31'd0, imem_req_o}, 32'd1);
            check("t2_ex_fetch", {31'd0, ex_o}, 32'd0);
        end
        tick();
        check("t2_ex_dec", {31'd0, ex_o}, 32'd0);
        run_i = 1'b0;
        tick();
        check("t2_ex_exec", {31'd0, ex_o}, 32'd1);
        tick();
        check("t2_ex_post", {31'd0, ex_o}, 32'd0);
        check("t2_pc", {27'd0, pc_o}, 32'd2);
        tick();
        check("t2_idle_req", {31'd0, imem_req_o}, 32'd0);

`ifdef FETCH_HALT_EN
        do_instr(0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2);
        check("halt_set", {31'd0, halt_o}, 32'd1);
        run_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_noreq", {31'd0, imem_req_o}, 32'd0);
            check("halt_hold", {31'd0, halt_o}, 32'd1);
        end
        run_i = 1'b0;
`else
        do_instr(0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd3);
        check("op7_nohalt", {31'd0, halt_o}, 32'd0);
        do_instr(0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4);
        do_instr(1, 1'b1, 1'b1, 1'b0, 5'd4, 5'd16);
        do_instr(0, 1'b1, 1'b0, 1'b1, 5'd16, 5'd5);
        do_instr(0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd6);
        do_instr(2, 1'b1, 1'b0, 1'b0, 5'd6, 5'd31);
        do_instr(0, 1'b1, 1'b1, 1'b1, 5'd31, 5'd0);
        do_instr(0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1);

        // Stray acks while idle must not load IR or start anything
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spur_req", {31'd0, imem_req_o}, 32'd0);
            check("spur_ir", {24'd0, op_o, arg_o}, 32'h41);
            check("spur_pc", {27'd0, pc_o}, 32'd1);
        end
        spur = 1'b0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset; asynchronous, active-high.
REQ-003 run_i  input  1  run enable; level-sensitive, sampled only in IDLE and at end of EXEC.
REQ-004 imem_req_o  output  1  instruction memory read request.
REQ-005 imem_addr_o  output  5  read address, equal to PC.
REQ-006 imem_ack_i  input  1  memory ack; imem_data_i valid in the same cycle.
REQ-007 imem_data_i  input  8  instruction word: [7:5] opcode, [4:0] operand address.
REQ-008 op_o  output  3  IR[7:5]; opcode fed to the control unit.
REQ-009 arg_o  output  5  IR[4:0]; operand or jump target.
REQ-010 ex_o  output  1  execute strobe; datapath qualifies wr/wm/wf with it.
REQ-011 jmp_i  input  1  jump request from the control unit.
REQ-012 z_i, c_i  input  1 each  zero and carry flags from the status register.
REQ-013 pc_o  output  5  current PC.
REQ-014 halt_o  output  1  sequencer halted (only with FETCH_HALT_EN).

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC and, with FETCH_HALT_EN, HALT.
REQ-016 IDLE: go to FETCH the next cycle if run_i=1; otherwise stay.
REQ-017 FETCH: drive imem_req_o=1 and imem_addr_o=PC, both held stable until imem_ack_i=1.
REQ-018 FETCH with imem_ack_i=1: load IR from imem_data_i and go to DECODE. Wait cycles are unbounded.
REQ-019 imem_ack_i outside FETCH SHALL be ignored.
REQ-020 DECODE: one cycle with ex_o=0. op_o/arg_o are stable from DECODE through EXEC.
REQ-021 EXEC: one cycle with ex_o=1, asserted in no other state.
REQ-022 Jump taken = jmp_i AND (op=100, or op=101 AND z_i, or op=110 AND c_i); flags are sampled in EXEC.
REQ-023 End of EXEC:
- PC <= arg_o if jump taken, else PC+1 modulo 32 (31 wraps to 0).
- Next state FETCH if run_i=1, else IDLE.
REQ-024 Minimum latency is 3 cycles per instruction (ack in first FETCH cycle); each FETCH wait cycle adds one.
REQ-025 run_i=0 during FETCH/DECODE SHALL NOT abort: the instruction completes, then the FSM goes to IDLE.
REQ-026 imem_req_o SHALL be 0 in every state except FETCH.

Reset
REQ-027 rst_i=1 SHALL immediately set:
- state IDLE, PC=0, IR=0;
- imem_req_o=0, ex_o=0, halt_o=0, op_o=0, arg_o=0, imem_addr_o=0, pc_o=0.
REQ-028 Reset mid-fetch or mid-EXEC SHALL discard the instruction with no ex_o pulse and no PC update.
REQ-029 After rst_i deasserts, the first FETCH SHALL use address 0.

Configuration
REQ-030 Macro FETCH_HALT_EN:
- Defined: opcode 111 in EXEC gives ex_o=1 for that cycle, PC unchanged, then HALT. HALT holds halt_o=1, imem_req_o=0, ex_o=0, and ignores run_i until reset.
- Undefined: opcode 111 executes as any non-jump opcode (PC+1), no HALT state exists, halt_o is tied 0.

Verification
REQ-031 Reset, run_i=1, mem[0]=0x41 with ack in the first FETCH cycle:
- imem_req_o=1, addr 0 in cycle 1; op_o=010, arg_o=00001 in cycle 2; ex_o=1 in cycle 3; PC=1 in cycle 4.
REQ-032 Ack delayed 4 cycles: imem_addr_o is stable all 5 FETCH cycles, and ex_o pulses exactly once, 2 cycles after the ack.
REQ-033 Jump cases, with jmp_i=1 in EXEC:
- op=101, arg=0x10, z_i=0: PC becomes PC+1.
- Same with z_i=1: PC becomes 0x10.
- op=110, c_i=1: PC becomes arg.
REQ-034 PC=31 with a non-jump instruction: the next fetch address is 0.
REQ-035 Control timing:
- run_i dropped during DECODE: EXEC completes, then IDLE with imem_req_o=0.
- rst_i pulsed during FETCH: ex_o stays 0 and PC returns to 0.
REQ-036 FETCH_HALT_EN defined, mem[2]=0xE0: halt_o=1 after EXEC, PC=2, and no further imem_req_o. Undefined: the next fetch is from address 3.
